fifo_scoreboard: RTL

FIFO_SCOREBOARD -- requirements
Module: fifo_scoreboard

---
 rtl/fifo_scoreboard_pkg.sv | 14 +
 rtl/fifo_scoreboard_chan.sv | 133 +++++++++++++
 rtl/fifo_scoreboard.sv | 72 +++++++
 3 files changed

// File: rtl/fifo_scoreboard_pkg.sv
// Shared types for the FIFO scoreboard: per-channel verdict state and occupancy sizing.
package fifo_scoreboard_pkg;

  typedef enum logic {
    ST_OK   = 1'b0,
    ST_FAIL = 1'b1
  } chan_state_e;

  // Occupancy needs one bit beyond the pointer width so full and empty differ.
  function automatic int occ_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_scoreboard_chan.sv
// One scoreboard channel: reference queue of written data, compared against every read.
module fifo_scoreboard_chan
  import fifo_scoreboard_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int MODEL_DEPTH  = 16,
  parameter int ALLOW_BYPASS = 0,
  parameter int COUNT_W      = 32
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_cg,
  input  logic                         i_clear,
  input  logic [WIDTH-1:0]             i_wdata,
  input  logic                         i_wvalid,
  input  logic                         i_wready,
  input  logic [WIDTH-1:0]             i_rdata,
  input  logic                         i_rvalid,
  input  logic                         i_rready,
  output logic                         o_mismatch,
  output logic                         o_underflow,
  output logic                         o_overflow,
  output logic                         o_err_d,
  output logic [COUNT_W-1:0]           o_nPushed,
  output logic [COUNT_W-1:0]           o_nPopped,
  output logic [$clog2(MODEL_DEPTH):0] o_nOutstanding,
  output logic [WIDTH-1:0]             o_expected,
  output logic [WIDTH-1:0]             o_observed
);

  localparam int AW = $clog2(MODEL_DEPTH);
  localparam int OW = occ_w(MODEL_DEPTH);

  logic [WIDTH-1:0]   mem_q [MODEL_DEPTH];
  logic [AW-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic [OW-1:0]      occ_q, occ_d;
  logic [COUNT_W-1:0] npush_q, npush_d, npop_q, npop_d;
  logic [WIDTH-1:0]   exp_q, exp_d, obs_q, obs_d, cmp;
  logic               mm_q, mm_d, uf_q, uf_d, of_q, of_d;
  chan_state_e        state_q, state_d;
  logic push, pop, clr, empty, full, bypass, pop_head, store;
  logic ev_mm, ev_uf, ev_of;

  assign push     = i_cg & i_wvalid & i_wready;
  assign pop      = i_cg & i_rvalid & i_rready;
  assign clr      = i_cg & i_clear;
  assign empty    = (occ_q == '0);
  assign full     = (occ_q == OW'(MODEL_DEPTH));
  assign bypass   = (ALLOW_BYPASS != 0) && empty && push && pop;
  assign pop_head = pop && !empty;
  // A push into a full queue still fits when the head leaves in the same cycle.
  assign store    = push && !bypass && (!full || pop);
  assign ev_uf    = pop && empty && !bypass;
  assign ev_of    = push && full && !pop;
  assign cmp      = bypass ? i_wdata : mem_q[rptr_q];
  assign ev_mm    = (pop_head || bypass) && (i_rdata != cmp);

  always_comb begin
    wptr_d  = store    ? wptr_q + AW'(1) : wptr_q;
    rptr_d  = pop_head ? rptr_q + AW'(1) : rptr_q;
    occ_d   = occ_q + OW'(store) - OW'(pop_head);
    npush_d = (push && !ev_of && npush_q != '1) ? npush_q + COUNT_W'(1) : npush_q;
    npop_d  = (pop && npop_q != '1) ? npop_q + COUNT_W'(1) : npop_q;
    mm_d    = mm_q | ev_mm;
    uf_d    = uf_q | ev_uf;
    of_d    = of_q | ev_of;
    exp_d   = exp_q;
    obs_d   = obs_q;
    state_d = state_q;
    if (ev_mm || ev_uf || ev_of) state_d = ST_FAIL;
    // Only the first failure (and only if it is a data miscompare) is captured.
    if (ev_mm && state_q == ST_OK) begin
      exp_d = cmp;
      obs_d = i_rdata;
    end
    if (clr) begin
      wptr_d  = '0;
      rptr_d  = '0;
      occ_d   = '0;
      npush_d = '0;
      npop_d  = '0;
      mm_d    = 1'b0;
      uf_d    = 1'b0;
      of_d    = 1'b0;
      exp_d   = '0;
      obs_d   = '0;
      state_d = ST_OK;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      occ_q   <= '0;
      npush_q <= '0;
      npop_q  <= '0;
      mm_q    <= 1'b0;
      uf_q    <= 1'b0;
      of_q    <= 1'b0;
      exp_q   <= '0;
      obs_q   <= '0;
      state_q <= ST_OK;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      occ_q   <= occ_d;
      npush_q <= npush_d;
      npop_q  <= npop_d;
      mm_q    <= mm_d;
      uf_q    <= uf_d;
      of_q    <= of_d;
      exp_q   <= exp_d;
      obs_q   <= obs_d;
      state_q <= state_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (store && !clr) mem_q[wptr_q] <= i_wdata;
  end

  assign o_mismatch     = mm_q;
  assign o_underflow    = uf_q;
  assign o_overflow     = of_q;
  assign o_err_d        = mm_d | uf_d | of_d;
  assign o_nPushed      = npush_q;
  assign o_nPopped      = npop_q;
  assign o_nOutstanding = occ_q;
  assign o_expected     = exp_q;
  assign o_observed     = obs_q;

endmodule

// File: rtl/fifo_scoreboard.sv
// Multi-channel FIFO scoreboard: NCHAN independent checkers plus a shared error summary.
module fifo_scoreboard
  import fifo_scoreboard_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int MODEL_DEPTH  = 16,
  parameter int NCHAN        = 1,
  parameter int ALLOW_BYPASS = 0,
  parameter int COUNT_W      = 32
) (
  input  logic                                       i_clk,
  input  logic                                       i_rst,
  input  logic                                       i_cg,
  input  logic                                       i_clear,
  input  logic [NCHAN*WIDTH-1:0]                     i_wdata,
  input  logic [NCHAN-1:0]                           i_wvalid,
  input  logic [NCHAN-1:0]                           i_wready,
  input  logic [NCHAN*WIDTH-1:0]                     i_rdata,
  input  logic [NCHAN-1:0]                           i_rvalid,
  input  logic [NCHAN-1:0]                           i_rready,
  output logic [NCHAN-1:0]                           o_mismatch,
  output logic [NCHAN-1:0]                           o_underflow,
  output logic [NCHAN-1:0]                           o_overflow,
  output logic                                       o_error,
  output logic [NCHAN*COUNT_W-1:0]                   o_nPushed,
  output logic [NCHAN*COUNT_W-1:0]                   o_nPopped,
  output logic [NCHAN*($clog2(MODEL_DEPTH)+1)-1:0]   o_nOutstanding,
  output logic [NCHAN*WIDTH-1:0]                     o_expected,
  output logic [NCHAN*WIDTH-1:0]                     o_observed
);

  localparam int OW = occ_w(MODEL_DEPTH);

  logic [NCHAN-1:0] err_d;
  logic             error_q;

  for (genvar c = 0; c < NCHAN; c++) begin : g_chan
    fifo_scoreboard_chan #(
      .WIDTH(WIDTH), .MODEL_DEPTH(MODEL_DEPTH),
      .ALLOW_BYPASS(ALLOW_BYPASS), .COUNT_W(COUNT_W)
    ) u_chan (
      .i_clk          (i_clk),
      .i_rst          (i_rst),
      .i_cg           (i_cg),
      .i_clear        (i_clear),
      .i_wdata        (i_wdata[c*WIDTH +: WIDTH]),
      .i_wvalid       (i_wvalid[c]),
      .i_wready       (i_wready[c]),
      .i_rdata        (i_rdata[c*WIDTH +: WIDTH]),
      .i_rvalid       (i_rvalid[c]),
      .i_rready       (i_rready[c]),
      .o_mismatch     (o_mismatch[c]),
      .o_underflow    (o_underflow[c]),
      .o_overflow     (o_overflow[c]),
      .o_err_d        (err_d[c]),
      .o_nPushed      (o_nPushed[c*COUNT_W +: COUNT_W]),
      .o_nPopped      (o_nPopped[c*COUNT_W +: COUNT_W]),
      .o_nOutstanding (o_nOutstanding[c*OW +: OW]),
      .o_expected     (o_expected[c*WIDTH +: WIDTH]),
      .o_observed     (o_observed[c*WIDTH +: WIDTH])
    );
  end

  // Registered from the channels' next-state flags so o_error tracks the flags cycle for cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) error_q <= 1'b0;
    else       error_q <= |err_d;
  end

  assign o_error = error_q;

endmodule
